alu_arbiter: RTL and testbench

- Shares the single ALU instance between two requesters: port 0 is the execute stage and port 1 is the branch/address-compare unit.
- Each cycle it grants at most one requester. It drives that requester's operation onto the ALU, registers the result and flags, and returns them one cycle later.
- It keeps a per-requester last-result register that feeds the ALU prevRes input, so ALU_PASS returns the granted requester's own previous result.
- An optional lock gives a requester back-to-back ownership, bounded so the other requester cannot starve.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_rr2.sv | 46 ++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU encodings, flag layout and arbiter
// state constants for the ALU sharing logic.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_PASS = 4'hF;

  // flag vector is {z,s,c,v}
  localparam int FLAG_Z = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ARB_FREE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr2.sv
// Two-way round-robin grant with lock override.
// Only rr_ptr is stored here; lock state comes from the top.
module arb_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock_on,
  input  logic lock_id,
  input  logic rel,
  input  logic rel_port,
  output logic gnt0,
  output logic gnt1
);

  logic rr_ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (lock_on) begin
        gnt0 = req0 & ~lock_id;
        gnt1 = req1 & lock_id;
      end else if (req0 && req1) begin
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // a released owner hands priority to the other port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (rel) begin
      rr_ptr <= ~rel_port;
    end else if (!lock_on && req0 && req1) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates the shared ALU between execute (port 0)
// and branch/address-compare (port 1), one op per cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             lock0,
  input  logic [3:0]       sel0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             lock1,
  input  logic [3:0]       sel1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_prev_res,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_s,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  localparam logic [3:0] LMAX = 4'(LOCK_MAX);

  arb_state_t       state;
  logic [3:0]       lock_cnt;
  logic [3:0]       next_cnt;
  logic             idle;
  logic             lock_on;
  logic             lock_id;
  logic             rel;
  logic             rel_port;
  logic             own_lock;
  logic             own_req;
  logic             any_gnt;
  logic [3:0]       flags;
  logic [WIDTH-1:0] last_res0;
  logic [WIDTH-1:0] last_res1;

  assign lock_on  = state != ARB_FREE;
  assign lock_id  = state == ARB_LOCK1;
  assign any_gnt  = gnt0 | gnt1;
  assign own_lock = gnt1 ? lock1 : lock0;
  assign own_req  = lock_id ? req1 : req0;
  assign next_cnt = lock_on ? lock_cnt + 4'd1 : 4'd1;
  assign rel_port = lock_on ? lock_id : gnt1;

  always_comb begin
    rel = 1'b0;
    if (any_gnt) begin
      rel = own_lock ? (next_cnt >= LMAX) : lock_on;
    end else if (lock_on) begin
      rel = !own_req && idle;
    end
  end

  arb_rr2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .lock_on  (lock_on),
    .lock_id  (lock_id),
    .rel      (rel),
    .rel_port (rel_port),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_FREE;
      lock_cnt <= 4'd0;
      idle     <= 1'b0;
    end else if (rel) begin
      state    <= ARB_FREE;
      lock_cnt <= 4'd0;
      idle     <= 1'b0;
    end else if (any_gnt) begin
      idle <= 1'b0;
      if (own_lock) begin
        state    <= gnt1 ? ARB_LOCK1 : ARB_LOCK0;
        lock_cnt <= next_cnt;
      end
    end else if (lock_on) begin
      idle <= ~own_req;
    end
  end

  always_comb begin
    alu_sel      = ALU_PASS;
    alu_a        = '0;
    alu_b        = '0;
    alu_prev_res = '0;
    if (gnt0) begin
      alu_sel      = sel0;
      alu_a        = a0;
      alu_b        = b0;
      alu_prev_res = last_res0;
    end else if (gnt1) begin
      alu_sel      = sel1;
      alu_a        = a1;
      alu_b        = b1;
      alu_prev_res = last_res1;
    end
  end

  always_comb begin
    flags         = 4'd0;
    flags[FLAG_Z] = alu_z;
    flags[FLAG_S] = alu_s;
    flags[FLAG_C] = alu_c;
    flags[FLAG_V] = alu_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'd0;
      last_res0  <= '0;
      last_res1  <= '0;
    end else begin
      rsp_valid0 <= gnt0;
      rsp_valid1 <= gnt1;
      if (any_gnt) begin
        rsp_result <= alu_result;
        rsp_flags  <= flags;
      end
      if (gnt0) last_res0 <= alu_result;
      if (gnt1) last_res1 <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed
// vectors, ALU model as environment, decoupled monitor.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, lock0, req1, lock1;
  logic [3:0]  sel0, sel1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_prev_res, alu_result;
  logic        alu_z, alu_s, alu_c, alu_v;
  logic        rsp_valid0, rsp_valid1;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t q[$];
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .lock0(lock0), .sel0(sel0),
    .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .lock1(lock1), .sel1(sel1),
    .a1(a1), .b1(b1), .gnt1(gnt1),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_prev_res(alu_prev_res),
    .alu_result(alu_result),
    .alu_z(alu_z), .alu_s(alu_s),
    .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // shared ALU model (environment)
  logic [32:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[31:0];
        alu_c      = sum[32];
        alu_v      = (alu_a[31] == alu_b[31]) &&
                     (alu_result[31] != alu_a[31]);
      end
      ALU_SUB: begin
        sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = sum[31:0];
        alu_c      = sum[32];
        alu_v      = (alu_a[31] != alu_b[31]) &&
                     (alu_result[31] != alu_a[31]);
      end
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_PASS: alu_result = alu_prev_res;
      default:  alu_result = '0;
    endcase
    alu_z = alu_result == 32'd0;
    alu_s = alu_result[31];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pop and compare on every response
  always @(negedge clk) begin
    if (!rst && (rsp_valid0 || rsp_valid1)) begin
      ntests++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL rsp_unexpected: v0=%b v1=%b res=%h",
                 rsp_valid0, rsp_valid1, rsp_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rsp_valid0 !== ~e.port || rsp_valid1 !== e.port ||
            rsp_result !== e.res || rsp_flags !== e.flags) begin
          nfail++;
          $display("FAIL rsp: got v0=%b v1=%b res=%h fl=%h expected port=%0d res=%h fl=%h",
                   rsp_valid0, rsp_valid1, rsp_result, rsp_flags,
                   e.port, e.res, e.flags);
        end
      end
    end
  end

  task automatic idle_in();
    req0 = 0; lock0 = 0; sel0 = ALU_PASS; a0 = 0; b0 = 0;
    req1 = 0; lock1 = 0; sel1 = ALU_PASS; a1 = 0; b1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(
    input logic r0, l0, input logic [3:0] s0,
    input logic [31:0] x0, y0,
    input logic r1, l1, input logic [3:0] s1,
    input logic [31:0] x1, y1,
    input logic eg0, eg1,
    input logic [31:0] er, input logic [3:0] ef,
    input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    req0 = r0; lock0 = l0; sel0 = s0; a0 = x0; b0 = y0;
    req1 = r1; lock1 = l1; sel1 = s1; a1 = x1; b1 = y1;
    #1;
    chk(nm, {30'd0, gnt1, gnt0}, {30'd0, eg1, eg0});
    if (eg0 || eg1) begin
      e.port  = eg1;
      e.res   = er;
      e.flags = ef;
      q.push_back(e);
    end
  endtask

  task automatic nop(input string nm);
    step(0, 0, ALU_PASS, 0, 0, 0, 0, ALU_PASS, 0, 0,
         0, 0, 0, 0, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    req0 = 1'b1;
    #12;
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_valid", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", {28'd0, rsp_flags}, 32'd0);
    do_reset();

    // single op: 5+7
    step(1, 0, ALU_ADD, 5, 7, 0, 0, ALU_PASS, 0, 0,
         1, 0, 32'd12, 4'h0, "single_add");
    nop("single_idle");

    // contention, alternating grants
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        step(1, 0, ALU_SUB, 3, 3, 1, 0, ALU_SUB, 10, 4,
             1, 0, 32'd0, 4'hA, "cont_g0");
      else
        step(1, 0, ALU_SUB, 3, 3, 1, 0, ALU_SUB, 10, 4,
             0, 1, 32'd6, 4'h2, "cont_g1");
    end
    nop("cont_idle");

    // PASS returns own previous result
    step(0, 0, ALU_PASS, 0, 0, 1, 0, ALU_OR, 32'hF0, 32'h0F,
         0, 1, 32'hFF, 4'h0, "pass_or");
    step(1, 0, ALU_PASS, 0, 0, 1, 0, ALU_PASS, 0, 0,
         1, 0, 32'd0, 4'h8, "pass_p0");
    step(0, 0, ALU_PASS, 0, 0, 1, 0, ALU_PASS, 0, 0,
         0, 1, 32'hFF, 4'h0, "pass_p1");
    nop("pass_idle");

    // lock starvation bound
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1, 1, ALU_ADD, 1, 1, 1, 0, ALU_ADD, 2, 2,
           1, 0, 32'd2, 4'h0, "lock_g0");
    step(1, 1, ALU_ADD, 1, 1, 1, 0, ALU_ADD, 2, 2,
         0, 1, 32'd4, 4'h0, "lock_g1_c9");
    nop("lock_idle");

    // idle release after two empty cycles
    step(1, 1, ALU_AND, 32'hFF, 32'h0F, 0, 0, ALU_SUB, 10, 4,
         1, 0, 32'h0F, 4'h0, "idle_lock");
    step(0, 0, ALU_PASS, 0, 0, 1, 0, ALU_SUB, 10, 4,
         0, 0, 0, 0, "idle_c1");
    step(0, 0, ALU_PASS, 0, 0, 1, 0, ALU_SUB, 10, 4,
         0, 0, 0, 0, "idle_c2");
    step(0, 0, ALU_PASS, 0, 0, 1, 0, ALU_SUB, 10, 4,
         0, 1, 32'd6, 4'h2, "idle_c3");
    nop("idle_done");

    // async reset drops in-flight response
    step(1, 0, ALU_ADD, 5, 7, 0, 0, ALU_PASS, 0, 0,
         1, 0, 32'd12, 4'h0, "ar_add");
    @(posedge clk);
    #2;
    chk("ar_pre_valid", {31'd0, rsp_valid0}, 32'd1);
    chk("ar_pre_result", rsp_result, 32'd12);
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, rsp_valid0}, 32'd0);
    chk("ar_result", rsp_result, 32'd0);
    chk("ar_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    q.delete();
    idle_in();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, ALU_PASS, 0, 0, 0, 0, ALU_PASS, 0, 0,
         1, 0, 32'd0, 4'h8, "ar_pass0");
    nop("ar_idle");

    repeat (3) @(posedge clk);
    chk("sb_drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
